// File: rtl/bcd_pkg.sv
// Shared definitions for the sequential binary-to-BCD converter.
//   DIGIT_W : width of one BCD digit
//   state_e : converter FSM states
//   pow10   : constant 10**n, used for the saturation limit
//   clog2   : constant ceil(log2(v)), used for counter sizing
package bcd_pkg;

    localparam int unsigned DIGIT_W = 4;

    typedef enum logic [1:0] {
        IDLE,
        SHIFT,
        FINISH
    } state_e;

    // 64-bit result; adequate for DIGITS up to 19.
    function automatic logic [63:0] pow10(input int unsigned n);
        logic [63:0] r;
        r = 64'd1;
        for (int unsigned i = 0; i < n; i++) begin
            r = r * 64'd10;
        end
        return r;
    endfunction

    function automatic int unsigned clog2(input int unsigned v);
        int unsigned r;
        r = 0;
        while ((64'd1 << r) < 64'(v)) begin
            r = r + 1;
        end
        return r;
    endfunction

endpackage

// File: rtl/bcd_digit_adj.sv
// One double-dabble digit correction: add 3 when the digit is 5 or more, so the
// following left shift carries into the next decade.
//   din  : working BCD digit (0..9)
//   dout : corrected digit
module bcd_digit_adj
    import bcd_pkg::*;
(
    input  logic [DIGIT_W-1:0] din,
    output logic [DIGIT_W-1:0] dout
);

    always_comb begin
        dout = (din >= 4'd5) ? din + 4'd3 : din;
    end

endmodule

// File: rtl/seq_binary_to_bcd.sv
// Multi-cycle binary-to-BCD converter (double-dabble, one input bit per clock).
// A start in IDLE or FINISH captures binary; BIN_W shift cycles follow, then a
// one-cycle FINISH with done high. Results saturate to all nines on overflow
// and are held until the next done.
//
// Ports:
//   clk      : system clock
//   reset    : asynchronous active-high reset
//   start    : conversion request, ignored while busy
//   binary   : unsigned input, captured on an accepted start
//   busy     : conversion in progress
//   done     : one-cycle pulse, bcd_data/overflow updated
//   bcd_data : packed BCD result, units digit in [3:0]
//   overflow : last result exceeded 10**DIGITS-1 and was saturated
//   blank    : (BCD_BLANK_EN only) leading-zero blanking mask per digit
//
// Optional feature macro: BCD_BLANK_EN adds the blank output.
module seq_binary_to_bcd
    import bcd_pkg::*;
#(
    parameter int unsigned BIN_W  = 10,
    parameter int unsigned DIGITS = 4
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      start,
    input  logic [BIN_W-1:0]          binary,
    output logic                      busy,
    output logic                      done,
    output logic [DIGIT_W*DIGITS-1:0] bcd_data,
    output logic                      overflow
`ifdef BCD_BLANK_EN
    ,
    output logic [DIGITS-1:0]         blank
`endif
);

    localparam int unsigned WORK_W = DIGIT_W * (DIGITS + 1);
    localparam int unsigned OUT_W  = DIGIT_W * DIGITS;
    localparam int unsigned CAT_W  = WORK_W + BIN_W;
    localparam int unsigned CNT_W  = clog2(BIN_W + 1);

    localparam logic [63:0] LIMIT   = pow10(DIGITS) - 64'd1;
    localparam logic [63:0] MAX_IN  = (BIN_W >= 64) ? '1 : ((64'd1 << BIN_W) - 64'd1);
    // When every input value fits, the overflow path folds to constant zero.
    localparam logic        CAN_OVF = (MAX_IN > LIMIT);

    localparam logic [OUT_W-1:0] NINES = {DIGITS{4'h9}};

    state_e             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [BIN_W-1:0]   bin_q, bin_d;
    logic [WORK_W-1:0]  work_q, work_d;
    logic               ovf_q, ovf_d;
    logic [OUT_W-1:0]   bcd_q, bcd_d;
    logic               overflow_q, overflow_d;
    logic               done_q, done_d;

    logic [WORK_W-1:0]  adj;
    logic [CAT_W-1:0]   shift_cat;
    logic [WORK_W-1:0]  work_next;
    logic [BIN_W-1:0]   bin_next;

    // Extra top digit absorbs the carry so no bits are lost before saturation.
    for (genvar g = 0; g < DIGITS + 1; g++) begin : g_adj
        bcd_digit_adj u_adj (
            .din  (work_q[g*DIGIT_W +: DIGIT_W]),
            .dout (adj[g*DIGIT_W +: DIGIT_W])
        );
    end

    assign shift_cat = {adj[WORK_W-2:0], bin_q, 1'b0};
    assign work_next = shift_cat[CAT_W-1 -: WORK_W];
    assign bin_next  = shift_cat[BIN_W-1:0];

`ifdef BCD_BLANK_EN
    logic [DIGITS-1:0] blank_q, blank_d;
    logic [DIGITS-1:0] blank_calc;

    // Digit i blanks only if it and every higher digit are zero; units never blank.
    always_comb begin
        logic all_zero;
        all_zero   = 1'b1;
        blank_calc = '0;
        for (int i = int'(DIGITS) - 1; i >= 1; i--) begin
            all_zero      = all_zero & (work_next[i*DIGIT_W +: DIGIT_W] == 4'd0);
            blank_calc[i] = all_zero;
        end
    end
`endif

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        bin_d      = bin_q;
        work_d     = work_q;
        ovf_d      = ovf_q;
        bcd_d      = bcd_q;
        overflow_d = overflow_q;
        done_d     = 1'b0;
`ifdef BCD_BLANK_EN
        blank_d    = blank_q;
`endif
        unique case (state_q)
            IDLE, FINISH: begin
                state_d = IDLE;
                if (start) begin
                    bin_d   = binary;
                    work_d  = '0;
                    cnt_d   = CNT_W'(BIN_W);
                    ovf_d   = CAN_OVF && (64'(binary) > LIMIT);
                    state_d = SHIFT;
                end
            end
            SHIFT: begin
                work_d = work_next;
                bin_d  = bin_next;
                cnt_d  = cnt_q - CNT_W'(1);
                if (cnt_q == CNT_W'(1)) begin
                    state_d    = FINISH;
                    done_d     = 1'b1;
                    bcd_d      = ovf_q ? NINES : work_next[OUT_W-1:0];
                    overflow_d = ovf_q;
`ifdef BCD_BLANK_EN
                    blank_d    = ovf_q ? '0 : blank_calc;
`endif
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            bin_q      <= '0;
            work_q     <= '0;
            ovf_q      <= 1'b0;
            bcd_q      <= '0;
            overflow_q <= 1'b0;
            done_q     <= 1'b0;
`ifdef BCD_BLANK_EN
            blank_q    <= '0;
`endif
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            bin_q      <= bin_d;
            work_q     <= work_d;
            ovf_q      <= ovf_d;
            bcd_q      <= bcd_d;
            overflow_q <= overflow_d;
            done_q     <= done_d;
`ifdef BCD_BLANK_EN
            blank_q    <= blank_d;
`endif
        end
    end

    assign busy     = (state_q == SHIFT);
    assign done     = done_q;
    assign bcd_data = bcd_q;
    assign overflow = overflow_q;
`ifdef BCD_BLANK_EN
    assign blank    = blank_q;
`endif

endmodule

// File: tb/tb_seq_binary_to_bcd.sv
// Directed bench for seq_binary_to_bcd: default 10-bit/4-digit instance, a
// 2-digit instance for saturation, and a 1-bit/1-digit instance for the
// degenerate width. Inputs change and outputs are sampled on the falling edge.
module tb_seq_binary_to_bcd;

    logic clk   = 1'b0;
    logic reset = 1'b0;

    logic        start_a = 1'b0;
    logic [9:0]  bin_a   = '0;
    logic        busy_a, done_a, ovf_a;
    logic [15:0] bcd_a;

    logic        start_b = 1'b0;
    logic [9:0]  bin_b   = '0;
    logic        busy_b, done_b, ovf_b;
    logic [7:0]  bcd_b;

    logic        start_c = 1'b0;
    logic [0:0]  bin_c   = '0;
    logic        busy_c, done_c, ovf_c;
    logic [3:0]  bcd_c;

`ifdef BCD_BLANK_EN
    logic [3:0]  blank_a;
    logic [1:0]  blank_b;
    logic [0:0]  blank_c;
`endif

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    seq_binary_to_bcd #(.BIN_W(10), .DIGITS(4)) u_dut_a (
        .clk      (clk),
        .reset    (reset),
        .start    (start_a),
        .binary   (bin_a),
        .busy     (busy_a),
        .done     (done_a),
        .bcd_data (bcd_a),
        .overflow (ovf_a)
`ifdef BCD_BLANK_EN
        ,
        .blank    (blank_a)
`endif
    );

    seq_binary_to_bcd #(.BIN_W(10), .DIGITS(2)) u_dut_b (
        .clk      (clk),
        .reset    (reset),
        .start    (start_b),
        .binary   (bin_b),
        .busy     (busy_b),
        .done     (done_b),
        .bcd_data (bcd_b),
        .overflow (ovf_b)
`ifdef BCD_BLANK_EN
        ,
        .blank    (blank_b)
`endif
    );

    seq_binary_to_bcd #(.BIN_W(1), .DIGITS(1)) u_dut_c (
        .clk      (clk),
        .reset    (reset),
        .start    (start_c),
        .binary   (bin_c),
        .busy     (busy_c),
        .done     (done_c),
        .bcd_data (bcd_c),
        .overflow (ovf_c)
`ifdef BCD_BLANK_EN
        ,
        .blank    (blank_c)
`endif
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic done_of(input int sel);
        case (sel)
            0:       return done_a;
            1:       return done_b;
            default: return done_c;
        endcase
    endfunction

    // Call on a falling edge; returns on the falling edge of cycle 1.
    task automatic do_start(input int sel, input logic [9:0] val);
        case (sel)
            0:       begin start_a = 1'b1; bin_a = val;    end
            1:       begin start_b = 1'b1; bin_b = val;    end
            default: begin start_c = 1'b1; bin_c = val[0]; end
        endcase
        @(negedge clk);
        start_a = 1'b0;
        start_b = 1'b0;
        start_c = 1'b0;
    endtask

    // Bounded wait; cyc is the cycle number (1 = first after acceptance) of done.
    task automatic wait_done(input int sel, input string tag, output int cyc);
        cyc = 1;
        while (!done_of(sel) && cyc < 40) begin
            @(negedge clk);
            cyc++;
        end
        check({tag, "_done_seen"}, 64'(done_of(sel)), 64'd1);
    endtask

    initial begin
        int          cyc;
        int          n_done;
        logic [15:0] busy_mask;
        logic [15:0] done_mask;
        logic [15:0] got;

        #1 reset = 1'b1;
        repeat (3) @(negedge clk);
        reset = 1'b0;

        // Reset state
        check("rst_busy", 64'(busy_a), 64'd0);
        check("rst_done", 64'(done_a), 64'd0);
        check("rst_bcd",  64'(bcd_a),  64'd0);
        check("rst_ovf",  64'(ovf_a),  64'd0);

        // Zero: busy cycles 1..10, done cycle 11
        busy_mask = '0;
        done_mask = '0;
        got       = 16'hffff;
        do_start(0, 10'd0);
        for (int n = 1; n <= 13; n++) begin
            busy_mask[n] = busy_a;
            done_mask[n] = done_a;
            if (done_a) got = bcd_a;
            @(negedge clk);
        end
        check("zero_busy_window", 64'(busy_mask), 64'h07fe);
        check("zero_done_window", 64'(done_mask), 64'h0800);
        check("zero_bcd",         64'(got),       64'h0000);
        check("zero_ovf",         64'(ovf_a),     64'd0);

        // Back-to-back, second start in the FINISH cycle
        do_start(0, 10'd300);
        wait_done(0, "b2b_300", cyc);
        check("b2b_300_lat", 64'(cyc),   64'd11);
        check("b2b_300_bcd", 64'(bcd_a), 64'h0300);
        check("b2b_300_ovf", 64'(ovf_a), 64'd0);
        do_start(0, 10'd1023);
        wait_done(0, "b2b_1023", cyc);
        check("b2b_1023_gap", 64'(cyc),   64'd11);
        check("b2b_1023_bcd", 64'(bcd_a), 64'h1023);
        check("b2b_1023_ovf", 64'(ovf_a), 64'd0);
`ifdef BCD_BLANK_EN
        check("b2b_1023_blank", 64'(blank_a), 64'h0);
`endif
        @(negedge clk);
        check("hold_bcd", 64'(bcd_a), 64'h1023);

        // Two-digit saturation
        do_start(1, 10'd150);
        wait_done(1, "sat_150", cyc);
        check("sat_150_lat", 64'(cyc),   64'd11);
        check("sat_150_bcd", 64'(bcd_b), 64'h99);
        check("sat_150_ovf", 64'(ovf_b), 64'd1);
`ifdef BCD_BLANK_EN
        check("sat_150_blank", 64'(blank_b), 64'h0);
`endif
        do_start(1, 10'd42);
        wait_done(1, "sat_42", cyc);
        check("sat_42_bcd", 64'(bcd_b), 64'h42);
        check("sat_42_ovf", 64'(ovf_b), 64'd0);
        do_start(1, 10'd99);
        wait_done(1, "sat_99", cyc);
        check("sat_99_bcd", 64'(bcd_b), 64'h99);
        check("sat_99_ovf", 64'(ovf_b), 64'd0);

        // Starts during busy are ignored
        @(negedge clk);
        n_done = 0;
        got    = '0;
        do_start(0, 10'd123);
        for (int n = 1; n <= 25; n++) begin
            if (n == 3) begin start_a = 1'b1; bin_a = 10'd456; end
            if (n == 4) begin start_a = 1'b0; bin_a = 10'd0;   end
            if (n == 7) begin start_a = 1'b1; bin_a = 10'd789; end
            if (n == 8) begin start_a = 1'b0; bin_a = 10'd0;   end
            if (done_a) begin
                n_done++;
                got = bcd_a;
            end
            @(negedge clk);
        end
        check("ignore_done_count", 64'(n_done), 64'd1);
        check("ignore_bcd",        64'(got),    64'h0123);

        // Asynchronous reset mid-SHIFT
        do_start(0, 10'd555);
        repeat (4) @(negedge clk);
        check("abort_busy_before", 64'(busy_a), 64'd1);
        #2 reset = 1'b1;
        #1;
        check("abort_busy", 64'(busy_a), 64'd0);
        check("abort_done", 64'(done_a), 64'd0);
        check("abort_bcd",  64'(bcd_a),  64'd0);
        @(negedge clk);
        @(negedge clk);
        reset  = 1'b0;
        n_done = 0;
        for (int n = 0; n < 20; n++) begin
            if (done_a) n_done++;
            @(negedge clk);
        end
        check("abort_no_done", 64'(n_done), 64'd0);
        do_start(0, 10'd987);
        wait_done(0, "after_rst", cyc);
        check("after_rst_lat", 64'(cyc),   64'd11);
        check("after_rst_bcd", 64'(bcd_a), 64'h0987);

        // Digit boundaries and blanking
        do_start(0, 10'd999);
        wait_done(0, "v999", cyc);
        check("v999_bcd", 64'(bcd_a), 64'h0999);
`ifdef BCD_BLANK_EN
        check("v999_blank", 64'(blank_a), 64'b1000);
`endif
        do_start(0, 10'd7);
        wait_done(0, "v7", cyc);
        check("v7_bcd", 64'(bcd_a), 64'h0007);
`ifdef BCD_BLANK_EN
        check("v7_blank", 64'(blank_a), 64'b1110);
`endif
        do_start(0, 10'd0);
        wait_done(0, "v0", cyc);
        check("v0_bcd", 64'(bcd_a), 64'h0000);
`ifdef BCD_BLANK_EN
        check("v0_blank", 64'(blank_a), 64'b1110);
`endif
        do_start(0, 10'd1000);
        wait_done(0, "v1000", cyc);
        check("v1000_bcd", 64'(bcd_a), 64'h1000);
`ifdef BCD_BLANK_EN
        check("v1000_blank", 64'(blank_a), 64'b0000);
`endif

        // Single-bit input: one SHIFT cycle, result equals the bit
        do_start(2, 10'd1);
        wait_done(2, "w1_one", cyc);
        check("w1_one_lat", 64'(cyc),   64'd2);
        check("w1_one_bcd", 64'(bcd_c), 64'h1);
        check("w1_one_ovf", 64'(ovf_c), 64'd0);
        do_start(2, 10'd0);
        wait_done(2, "w1_zero", cyc);
        check("w1_zero_bcd", 64'(bcd_c), 64'h0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/seq_binary_to_bcd.md
Name: seq_binary_to_bcd

Overview:
Multi-cycle, parametrised binary-to-BCD converter for the score and HUD display path.
- Uses iterative double-dabble (shift-add-3), one bit per clock, with a start/busy/done handshake.
- Generalises the fixed 10-bit combinational converter to any input width and digit count.
- Adds overflow saturation and a registered, held result.
- Feeds the seven-segment / on-screen digit renderers.

Parameters:
BIN_W, 10, input binary width in bits (>=1)
DIGITS, 4, number of BCD output digits (>=1)

Ports:
clk  input  1  system clock
reset  input  1  asynchronous active-high reset
start  input  1  request conversion of binary; sampled only when not busy
binary  input  BIN_W  unsigned value; captured on accepted start
busy  output  1  high while conversion in progress
done  output  1  one-cycle pulse: bcd_data/overflow valid and updated
bcd_data  output  4*DIGITS  packed BCD, digit 0 (units) in [3:0]
overflow  output  1  last result exceeded 10^DIGITS-1 (saturated)

Behaviour:
- Clock and reset: one clock domain (clk). Reset is asynchronous, active-high. All flops clear immediately on reset assertion.
- Reset values: busy=0, done=0, bcd_data=0, overflow=0, FSM=IDLE, shift counter=0.
- FSM states: IDLE, SHIFT, FINISH.
- IDLE:
  - start=1: latch binary into shift register, clear working BCD register, load counter=BIN_W, go to SHIFT.
  - busy=1 from the next cycle.
- SHIFT, each cycle:
  - Every working nibble >=5 gets +3 (per-digit, 4-bit wrap-free since max 4+3... nibble<=9 before add).
  - Then the {bcd, bin} concatenation shifts left by 1.
  - Counter decrements. When the counter reaches 1 on the current cycle, go to FINISH.
- FINISH (one cycle):
  - bcd_data and overflow are registered and done=1. busy=0 this cycle. Return to IDLE.
- Latency: start sampled at edge N gives done high during cycle N+BIN_W+1, with bcd_data valid in the same cycle. Throughput is one conversion per BIN_W+2 cycles, or BIN_W+1 if start is asserted in the FINISH cycle.
- start during FINISH is accepted (treated as IDLE). start during SHIFT is ignored, not queued. binary changes after acceptance have no effect.
- Overflow:
  - Condition: latched value > 10^DIGITS-1 (localparam). This is evaluated at capture, using a registered flag.
  - On overflow: bcd_data = all digits 9, overflow=1.
  - If 2^BIN_W-1 <= 10^DIGITS-1, overflow is constant 0.
- Working BCD register is sized DIGITS+1 nibbles internally to avoid carry loss. Only the low DIGITS nibbles are exported.
- bcd_data and overflow hold the last result until the next done. They are not cleared at start.
- Reset mid-conversion aborts: no done pulse, outputs return to 0.
- BIN_W=1: a single SHIFT cycle, and the result equals the input bit.

Optional Feature:
Macro BCD_BLANK_EN.
- Defined: adds output blank, width DIGITS, reset 0.
  - Registered alongside bcd_data at done.
  - blank[i]=1 if digit i and all higher digits are 0, for i>=1.
  - blank[0] is always 0, so the value zero shows a single "0".
  - On overflow, blank = 0.
- Undefined: port and logic absent. All other behaviour is identical.

Decomposition:
- Package bcd_pkg:
  - DIGIT_W=4.
  - State enum (IDLE, SHIFT, FINISH).
  - Constant function pow10(n) used for the saturation limit.
  - Constant function clog2 for the counter width.
- Sub-module bcd_digit_adj: 4-bit in/out, add 3 if >=5. Instantiated DIGITS+1 times via generate in the SHIFT datapath.

Test Plan:
- Defaults, start with binary=0: done at cycle 11, bcd_data=16'h0000, overflow=0, busy high for exactly cycles 1-10.
- binary=300 then binary=1023, back-to-back with start asserted in the FINISH cycle: bcd_data=16'h0300, then 16'h1023. Second done comes exactly 11 cycles after the first.
- BIN_W=10, DIGITS=2, binary=150: bcd_data=8'h99, overflow=1. Then binary=42 gives 8'h42, overflow=0.
- start pulsed at cycles 3 and 7 during busy with different binary values: exactly one done, and the result reflects the first value only.
- reset asserted asynchronously mid-SHIFT (cycle 5): busy, done and bcd_data go to 0 immediately, no done follows. A new start=1 after reset release converts normally.
- BCD_BLANK_EN with binary=7: blank=4'b1110. With binary=0: blank=4'b1110. With binary=1000: blank=4'b0000.
